midi_message_parser: RTL and testbench
======================================

// Module: midi_message_parser
// PURPOSE
//  Byte-level MIDI 1.0 stream parser that produces the midi_key / midi_velocity / midi_valid
//  event interface consumed by the video processor's note tracker and by the audio voice logic.
//  Sits after the UART receiver in the clk_100MHz domain. Handles running status,
//  real-time interleaving, SysEx/system-common skipping and channel filtering.
//  Emits one single-cycle event per accepted note message.
// PARAMETERS
//  CHANNEL  9  MIDI channel (0-15) accepted; 9 = GM drum channel 10
//  OMNI     0  1 = accept note messages on all channels, ignoring CHANNEL
// PORTS
//  clk_100MHz     in   1  system clock; the block's only clock
//  rst            in   1  asynchronous, active-high reset
//  rx_byte        in   8  received UART byte, valid when rx_valid=1
//  rx_valid       in   1  one-cycle strobe per received byte; may be asserted every cycle
//  midi_key       out  7  note number of the last emitted event
//  midi_velocity  out  7  velocity of the last emitted event (0 = note off)
//  midi_valid     out  1  one-cycle event strobe
//  parse_error    out  1  one-cycle strobe on a stray or truncated data byte sequence
// BEHAVIOUR
//  Reset (async, applies immediately): midi_key=0, midi_velocity=0, midi_valid=0, parse_error=0,
//   state=NO_STATUS, running status cleared.
//  States: NO_STATUS, WAIT_D1, WAIT_D2, SYSEX, SKIP_N (discard N remaining data bytes).
//  Byte classes are evaluated only on cycles with rx_valid=1; otherwise state holds.
//  - 0xF8-0xFF (real-time): ignored entirely; no state, running status or counter change.
//  - 0x80-0xEF (channel status): latch running status; go to WAIT_D1. If a message was
//    partially received, it is dropped and parse_error pulses in the next cycle.
//    Message data length: 0x8n/0x9n/0xAn/0xBn/0xEn = 2 bytes, 0xCn/0xDn = 1 byte.
//  - 0xF0: clear running status; go to SYSEX; data bytes discarded until any status byte.
//  - 0xF7: clear running status; go to NO_STATUS.
//  - 0xF1/0xF3: clear running status; SKIP_N with N=1. 0xF2: SKIP_N with N=2.
//    0xF4-0xF6: clear running status; go to NO_STATUS.
//  - Data byte (bit7=0): NO_STATUS -> discard and pulse parse_error. SYSEX -> discard.
//    SKIP_N -> decrement N; at 0 go to NO_STATUS. WAIT_D1 -> store D1; go to WAIT_D2 for
//    2-byte messages, else complete the message. WAIT_D2 -> complete the message.
//  - On completion: return to WAIT_D1 with running status retained (running status reuse).
//  Event generation on completion (registered; midi_valid high exactly 1 cycle after the
//   rx_valid cycle of the final data byte; key/velocity update in that same cycle and hold):
//   * 0x9n with channel match: velocity D2 != 0 -> emit key=D1, velocity=D2.
//   * 0x9n with D2 == 0 and 0x8n: note-off; handled per MIDI_NOTE_OFF_EN.
//   * All other channel messages, or a channel mismatch: no event.
//  Channel match: OMNI=1, or status[3:0]==CHANNEL[3:0].
//  Throughput: one byte per cycle sustained; no backpressure. Back-to-back completed
//   messages produce midi_valid on consecutive-enough cycles with no event dropped.
//  parse_error and midi_valid are independent; both may pulse in the same cycle.
// CONFIGURATION
//  MIDI_NOTE_OFF_EN defined: note-off (0x8n, or 0x9n with velocity 0) emits midi_valid with
//   key=D1 and velocity=0. The release velocity of 0x8n is discarded.
//  MIDI_NOTE_OFF_EN undefined (default): note-off messages are parsed and consumed with no event.
//   midi_velocity is therefore never 0 on a valid event.
// TESTING
//  1. 0x99,0x24,0x64 -> 1 cycle after last byte: midi_valid=1, key=0x24, vel=0x64; then valid=0.
//  2. 0x99,0x26,0x50,0x2A,0x7F (running status) -> two events: (0x26,0x50), then (0x2A,0x7F).
//  3. 0x99,0xF8,0x24,0xFE,0x40 -> real-time bytes ignored; single event (0x24,0x40).
//  4. 0x90,0x24,0x64 with CHANNEL=9, OMNI=0 -> no event. With OMNI=1 -> event (0x24,0x64).
//  5. 0x99,0x24,0x00 -> no event without MIDI_NOTE_OFF_EN; with it, event (0x24,0x00).
//  6. Data byte 0x30 after reset -> parse_error pulse, no event. Then 0x99,0x24,0x99,0x25,0x10
//     -> parse_error on the truncated message, then event (0x25,0x10).
//  7. 0xF0,0x7E,0x24,0x64,0xF7,0x24,0x64 -> no event and no parse_error on the SysEx data;
//     the bytes after 0xF7 pulse parse_error. Assert rst mid-message: outputs go to 0 and the
//     next bytes 0x24,0x64 produce no event.

Source files
------------

// File: rtl/midi_message_parser.sv
// midi_message_parser: MIDI 1.0 byte stream to note events, with running status and channel filter.
// Optional MIDI_NOTE_OFF_EN: note-off messages emit an event with velocity 0.
module midi_message_parser #(
    parameter int unsigned CHANNEL = 9,
    parameter bit          OMNI    = 1'b0
) (
    input  logic       clk_100MHz,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [6:0] midi_key,
    output logic [6:0] midi_velocity,
    output logic       midi_valid,
    output logic       parse_error
);
    typedef enum logic [2:0] {NO_STATUS, WAIT_D1, WAIT_D2, SYSEX, SKIP_N} state_t;
    localparam logic [3:0] CH = CHANNEL[3:0];
    state_t     state_q;
    logic [7:0] status_q;
    logic [1:0] skip_q;
    logic [6:0] d1_q, key_q, vel_q;
    logic       valid_q, err_q;
    logic       is_rt, is_chan, is_data, two_byte, match, complete, note_on, note_off;
    logic       emit_d, err_d;
    logic [6:0] vel_d;
    always_comb begin
        is_rt    = rx_byte[7:3] == 5'b11111;
        is_chan  = rx_byte[7] && rx_byte[7:4] != 4'hF;
        is_data  = !rx_byte[7];
        two_byte = status_q[7:4] != 4'hC && status_q[7:4] != 4'hD;
        match    = OMNI || status_q[3:0] == CH;
        complete = rx_valid && is_data && state_q == WAIT_D2;
        note_on  = match && status_q[7:4] == 4'h9 && rx_byte[6:0] != 7'd0;
        note_off = match && (status_q[7:4] == 4'h8 || (status_q[7:4] == 4'h9 && rx_byte[6:0] == 7'd0));
`ifdef MIDI_NOTE_OFF_EN
        emit_d   = complete && (note_on || note_off);
`else
        emit_d   = complete && note_on;
`endif
        vel_d    = note_on ? rx_byte[6:0] : 7'd0;
        // a new channel status while D1 is held means the previous message was truncated
        err_d    = rx_valid && ((is_chan && state_q == WAIT_D2) || (is_data && state_q == NO_STATUS));
    end
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            state_q  <= NO_STATUS;
            status_q <= '0;
            skip_q   <= '0;
            d1_q     <= '0;
            key_q    <= '0;
            vel_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= emit_d;
            err_q   <= err_d;
            if (emit_d) begin
                key_q <= d1_q;
                vel_q <= vel_d;
            end
            if (rx_valid && !is_rt) begin
                if (is_chan) begin
                    status_q <= rx_byte;
                    state_q  <= WAIT_D1;
                end else if (!is_data) begin
                    status_q <= '0;
                    skip_q   <= rx_byte == 8'hF2 ? 2'd2 : 2'd1;
                    state_q  <= rx_byte == 8'hF0 ? SYSEX :
                                rx_byte inside {8'hF1, 8'hF2, 8'hF3} ? SKIP_N : NO_STATUS;
                end else begin
                    case (state_q)
                        WAIT_D1: begin
                            d1_q    <= rx_byte[6:0];
                            state_q <= two_byte ? WAIT_D2 : WAIT_D1;
                        end
                        WAIT_D2: state_q <= WAIT_D1;
                        SKIP_N: begin
                            skip_q  <= skip_q - 2'd1;
                            state_q <= skip_q == 2'd1 ? NO_STATUS : SKIP_N;
                        end
                        default: state_q <= state_q;
                    endcase
                end
            end
        end
    end
    assign midi_key      = key_q;
    assign midi_velocity = vel_q;
    assign midi_valid    = valid_q;
    assign parse_error   = err_q;
endmodule

// File: tb/tb_midi_message_parser.sv
// tb_midi_message_parser: per-cycle vector table against a CHANNEL=9 parser and an OMNI parser.
module tb_midi_message_parser;
`ifdef MIDI_NOTE_OFF_EN
    localparam bit NOFF = 1'b1;
`else
    localparam bit NOFF = 1'b0;
`endif
    logic       clk_100MHz = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_byte = '0;
    logic       rx_valid = 1'b0;
    logic [6:0] midi_key, midi_velocity, o_key, o_vel;
    logic       midi_valid, parse_error, o_valid, o_err;
    int         checks = 0, errors = 0;
    midi_message_parser #(.CHANNEL(9), .OMNI(1'b0)) dut (
        .clk_100MHz(clk_100MHz), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .midi_key(midi_key), .midi_velocity(midi_velocity), .midi_valid(midi_valid),
        .parse_error(parse_error));
    midi_message_parser #(.CHANNEL(9), .OMNI(1'b1)) dut_omni (
        .clk_100MHz(clk_100MHz), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .midi_key(o_key), .midi_velocity(o_vel), .midi_valid(o_valid), .parse_error(o_err));
    always #5 clk_100MHz = ~clk_100MHz;
    typedef struct {
        bit         r;
        bit         v;
        logic [7:0] b;
        bit         ev;
        logic [6:0] ek;
        logic [6:0] evl;
        bit         ee;
        bit         ov;
    } vec_t;
    vec_t       tv[$];
    logic [6:0] hk = '0, hv = '0;
    task automatic add(input bit r, input bit v, input logic [7:0] b, input bit ev, input bit ee,
                       input bit ov, input logic [6:0] k, input logic [6:0] vl);
        if (r) begin
            hk = '0;
            hv = '0;
        end else if (ev) begin
            hk = k;
            hv = vl;
        end
        tv.push_back('{r, v, b, ev, hk, hv, ee, ov});
    endtask
    task automatic n(input logic [7:0] b);
        add(1'b0, 1'b1, b, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
    endtask
    task automatic x(input logic [7:0] b);
        add(1'b0, 1'b1, b, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0);
    endtask
    task automatic e(input logic [7:0] b, input logic [6:0] k, input logic [6:0] vl);
        add(1'b0, 1'b1, b, 1'b1, 1'b0, 1'b1, k, vl);
    endtask
    task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", nm, i, act, exp);
        end
    endtask
    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk_100MHz);
    endtask
    initial begin
        n(8'h99); n(8'h24); e(8'h64, 7'h24, 7'h64);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
        n(8'h99); n(8'h26); e(8'h50, 7'h26, 7'h50); n(8'h2A); e(8'h7F, 7'h2A, 7'h7F);
        n(8'h99); n(8'hF8); n(8'h24); n(8'hFE); e(8'h40, 7'h24, 7'h40);
        n(8'h90); n(8'h24); add(1'b0, 1'b1, 8'h64, 1'b0, 1'b0, 1'b1, 7'd0, 7'd0);
        n(8'h99); n(8'h24); add(1'b0, 1'b1, 8'h00, NOFF, 1'b0, NOFF, 7'h24, 7'h00);
        n(8'h89); n(8'h30); add(1'b0, 1'b1, 8'h40, NOFF, 1'b0, NOFF, 7'h30, 7'h00);
        n(8'hC9); n(8'h05); n(8'h06);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
        x(8'h30); n(8'h99); n(8'h24); x(8'h99); n(8'h25); e(8'h10, 7'h25, 7'h10);
        n(8'hF0); n(8'h7E); n(8'h24); n(8'h64); n(8'hF7); x(8'h24); x(8'h64);
        n(8'hF2); n(8'h01); n(8'h02); x(8'h03); n(8'hF1); n(8'h05); x(8'h06);
        n(8'hF3); n(8'h07); x(8'h08);
        repeat (2) @(negedge clk_100MHz);
        chk("reset_valid", -1, {7'd0, midi_valid}, 8'd0);
        chk("reset_err", -1, {7'd0, parse_error}, 8'd0);
        chk("reset_key", -1, {1'b0, midi_key}, 8'd0);
        chk("reset_vel", -1, {1'b0, midi_velocity}, 8'd0);
        for (int i = 0; i < tv.size(); i++) begin
            rst      = tv[i].r;
            rx_valid = tv[i].v;
            rx_byte  = tv[i].b;
            @(negedge clk_100MHz);
            chk("valid", i, {7'd0, midi_valid}, {7'd0, tv[i].ev});
            chk("key", i, {1'b0, midi_key}, {1'b0, tv[i].ek});
            chk("vel", i, {1'b0, midi_velocity}, {1'b0, tv[i].evl});
            chk("perr", i, {7'd0, parse_error}, {7'd0, tv[i].ee});
            chk("omni_valid", i, {7'd0, o_valid}, {7'd0, tv[i].ov});
        end
        send(8'h99);
        send(8'h24);
        rx_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_key", 100, {1'b0, midi_key}, 8'd0);
        chk("async_vel", 100, {1'b0, midi_velocity}, 8'd0);
        chk("async_valid", 100, {7'd0, midi_valid}, 8'd0);
        chk("async_err", 100, {7'd0, parse_error}, 8'd0);
        @(negedge clk_100MHz);
        rst = 1'b0;
        send(8'h24);
        chk("post_rst_valid1", 101, {7'd0, midi_valid}, 8'd0);
        send(8'h64);
        chk("post_rst_valid2", 102, {7'd0, midi_valid}, 8'd0);
        chk("post_rst_err", 102, {7'd0, parse_error}, 8'd1);
        send(8'h90);
        send(8'h24);
        send(8'h64);
        chk("ch0_valid", 103, {7'd0, midi_valid}, 8'd0);
        chk("omni_valid", 103, {7'd0, o_valid}, 8'd1);
        chk("omni_key", 103, {1'b0, o_key}, 8'h24);
        chk("omni_vel", 103, {1'b0, o_vel}, 8'h64);
        rx_valid = 1'b0;
        @(negedge clk_100MHz);
        chk("omni_valid_drop", 104, {7'd0, o_valid}, 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
